// File: rtl/tank_level_ctrl.sv
// Multi-tank water-level controller: per-channel fill FSM with hysteresis, timeout and
// latched errors, plus a shared lowest-index-first valve arbiter. Optional macro: TANK_FAULT_DEBOUNCE_EN.
module tank_level_ctrl #(
    parameter int N_TANKS      = 4,
    parameter int LEVEL_W      = 8,
    parameter int LOW_TH       = 64,
    parameter int HIGH_TH      = 192,
    parameter int FILL_TIMEOUT = 1000,
    parameter int MAX_ON       = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [N_TANKS*LEVEL_W-1:0]     level,
    input  logic [N_TANKS-1:0]             fault,
    input  logic [N_TANKS-1:0]             fault_ack,
    output logic [N_TANKS-1:0]             valve,
    output logic [N_TANKS-1:0]             err,
    output logic [N_TANKS-1:0]             timeout_flag,
    output logic [N_TANKS*3-1:0]           state_o,
    output logic [$clog2(N_TANKS+1)-1:0]   active_cnt
);

    localparam int TMR_W = $clog2(FILL_TIMEOUT + 1);
    localparam int CNT_W = $clog2(N_TANKS + 1);

    localparam logic [LEVEL_W-1:0] LOW_LVL  = LEVEL_W'(LOW_TH);
    localparam logic [LEVEL_W-1:0] HIGH_LVL = LEVEL_W'(HIGH_TH);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(FILL_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   TMR_MAX  = TMR_W'(FILL_TIMEOUT);

    localparam bit CFG_OK = (HIGH_TH > LOW_TH) && (MAX_ON >= 1) && (MAX_ON <= N_TANKS) &&
                            (FILL_TIMEOUT >= 1) && (DEBOUNCE_CYC >= 1);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("tank_level_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_FULL    = 3'd2,
        ST_FAULT   = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    state_e             state_q [N_TANKS];
    state_e             state_d [N_TANKS];
    logic [TMR_W-1:0]   timer_q [N_TANKS];
    logic [TMR_W-1:0]   timer_d [N_TANKS];
    logic [N_TANKS-1:0] valve_q, valve_d;
    logic [N_TANKS-1:0] err_q, err_d;
    logic [N_TANKS-1:0] tflag_q, tflag_d;
    logic [CNT_W-1:0]   active_q, active_d;

    logic [N_TANKS-1:0] at_low, at_high;
    logic [N_TANKS-1:0] fault_act;

`ifdef TANK_FAULT_DEBOUNCE_EN
    localparam int              DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_THR = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC);

    logic [DB_W-1:0] db_q [N_TANKS];

    // The current high sample counts as the last of the run, so the fault acts on the Nth edge.
    always_comb begin
        fault_act = '0;
        for (int i = 0; i < N_TANKS; i++) begin
            fault_act[i] = fault[i] && (db_q[i] >= DB_THR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TANKS; i++) begin
                db_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_TANKS; i++) begin
                if (!fault[i]) begin
                    db_q[i] <= '0;
                end else if (db_q[i] != DB_MAX) begin
                    db_q[i] <= db_q[i] + 1'b1;
                end
            end
        end
    end
`else
    assign fault_act = fault;
`endif

    always_comb begin
        at_low  = '0;
        at_high = '0;
        for (int i = 0; i < N_TANKS; i++) begin
            at_low[i]  = level[i*LEVEL_W +: LEVEL_W] <= LOW_LVL;
            at_high[i] = level[i*LEVEL_W +: LEVEL_W] >= HIGH_LVL;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < N_TANKS; i++) begin
            state_d[i] = state_q[i];
            if (state_q[i] == ST_FAULT || state_q[i] == ST_TIMEOUT) begin
                if (fault_ack[i] && !fault_act[i]) begin
                    state_d[i] = ST_IDLE;
                end
            end else if (fault_act[i]) begin
                state_d[i] = ST_FAULT;
            end else if (!enable) begin
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE: state_d[i] = at_low[i] ? ST_FILL : ST_FULL;
                    ST_FILL: begin
                        if (at_high[i]) begin
                            state_d[i] = ST_FULL;
                        end else if (valve_q[i] && timer_q[i] == TMR_LAST) begin
                            state_d[i] = ST_TIMEOUT;
                        end
                    end
                    ST_FULL: begin
                        if (at_low[i]) begin
                            state_d[i] = ST_FILL;
                        end
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end

            // Timer only advances on cycles the valve was actually open; waiting freezes it.
            if (state_d[i] != ST_FILL) begin
                timer_d[i] = '0;
            end else if (valve_q[i] && timer_q[i] != TMR_MAX) begin
                timer_d[i] = timer_q[i] + 1'b1;
            end else begin
                timer_d[i] = timer_q[i];
            end
        end
    end

    // Arbitrating on the next state lets a released grant pass on at the very same edge.
    always_comb begin
        int n;
        n       = 0;
        valve_d = '0;
        err_d   = '0;
        tflag_d = '0;
        for (int i = 0; i < N_TANKS; i++) begin
            if (state_d[i] == ST_FILL && n < MAX_ON) begin
                valve_d[i] = 1'b1;
                n          = n + 1;
            end
            err_d[i]   = (state_d[i] == ST_FAULT) || (state_d[i] == ST_TIMEOUT);
            tflag_d[i] = (state_d[i] == ST_TIMEOUT);
        end
        active_d = CNT_W'(n);
    end

    // NOTE: state is updated with non-blocking assignments only; the per-channel arrays are
    // small control registers and are all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TANKS; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
            end
            valve_q  <= '0;
            err_q    <= '0;
            tflag_q  <= '0;
            active_q <= '0;
        end else begin
            for (int i = 0; i < N_TANKS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            valve_q  <= valve_d;
            err_q    <= err_d;
            tflag_q  <= tflag_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_o = '0;
        for (int i = 0; i < N_TANKS; i++) begin
            state_o[i*3 +: 3] = state_q[i];
        end
    end

    assign valve        = valve_q;
    assign err          = err_q;
    assign timeout_flag = tflag_q;
    assign active_cnt   = active_q;

endmodule

// File: doc/tank_level_ctrl.md
Name: tank_level_ctrl

Overview:
- Parametrised multi-tank water-level controller: N_TANKS independent channels, each with a multi-bit level reading and a pump-fault input.
- Per channel: drives a fill valve with hysteresis, fill-timeout supervision and a latched error with acknowledge.
- A shared arbiter caps how many valves may be open at once.
- Sits between the level-sensor front end and the valve/alarm drivers.

Parameters:
- N_TANKS, 4, number of channels
- LEVEL_W, 8, level reading width (unsigned)
- LOW_TH, 64, level at or below which filling starts
- HIGH_TH, 192, level at or above which filling stops; must be > LOW_TH
- FILL_TIMEOUT, 1000, max granted-fill cycles before timeout error
- MAX_ON, 2, max simultaneously open valves (1..N_TANKS)
- DEBOUNCE_CYC, 4, fault filter length (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- enable  in  1  global run enable
- level  in  N_TANKS*LEVEL_W  per-channel level; channel i occupies bits [i*LEVEL_W +: LEVEL_W]
- fault  in  N_TANKS  per-channel pump fault, active high
- fault_ack  in  N_TANKS  per-channel error acknowledge, one-cycle pulse
- valve  out  N_TANKS  valve open, 1 = water
- err  out  N_TANKS  channel in FAULT or TIMEOUT
- timeout_flag  out  N_TANKS  channel in TIMEOUT (subset of err)
- state_o  out  N_TANKS*3  per-channel state code, for debug
- active_cnt  out  $clog2(N_TANKS+1)  number of valves currently open

Behaviour:
- Reset asserted (reset=0), async: all channels go to IDLE, timers clear. valve=0, err=0, timeout_flag=0, active_cnt=0, state_o=0.
- State codes (3-bit): IDLE=0, FILL=1, FULL=2, FAULT=3, TIMEOUT=4. Codes 5-7 are illegal and recover to IDLE on the next edge.
- Transitions are evaluated every rising edge, first match wins:
  - fault[i]=1 in any state except TIMEOUT -> FAULT. Fault beats enable and level.
  - FAULT or TIMEOUT: stay until fault_ack[i]=1 and fault[i]=0 in the same cycle -> IDLE. An ack while fault=1 is ignored.
  - enable=0: IDLE/FILL/FULL -> IDLE, timer clears.
  - IDLE, enable=1: level<=LOW_TH -> FILL, else -> FULL.
  - FILL: level>=HIGH_TH -> FULL, timer clears. Timer==FILL_TIMEOUT-1 while granted -> TIMEOUT.
  - FULL: level<=LOW_TH -> FILL. Levels between the thresholds hold the current state (hysteresis).
- Arbitration is combinational from registered state.
  - Channels in FILL are granted lowest-index first, up to MAX_ON.
  - valve[i] = (state==FILL) and granted.
  - An ungranted FILL channel waits with its timer frozen, not cleared.
  - A grant released by one channel goes to the next waiting channel on the same edge the releasing state changes.
- Timer:
  - Per channel, width $clog2(FILL_TIMEOUT+1).
  - Increments only while valve[i]=1; saturates. Clears on leaving FILL.
- Latency: a condition true before edge k changes state at edge k; valve/err reflect the new state in the same cycle (Moore outputs, no extra register stage).
- Outputs:
  - err[i] = FAULT or TIMEOUT.
  - timeout_flag[i] = TIMEOUT.
  - active_cnt = popcount(valve).
- Simultaneous events:
  - fault together with level crossing -> FAULT.
  - fault_ack together with a new fault rise -> stays FAULT.
  - enable drop during TIMEOUT has no effect.
- Reset mid-fill closes all valves asynchronously and drops the timer.

Optional Feature:
- Macro TANK_FAULT_DEBOUNCE_EN.
- Defined: fault[i] acts only after DEBOUNCE_CYC consecutive high samples, using a per-channel counter that clears on any low sample. The filtered fault is also used in the ack-exit condition, so fault must read low filtered.
- Undefined: raw fault acts at the next edge; no counters are instantiated.

Test Plan:
- Reset, enable=1, level0=50, others=100 -> ch0 FILL (valve=0001 one edge after enable), others FULL. Raise level0 to 200 -> ch0 FULL, valve=0000.
- Hysteresis: ch0 FULL, level0 swept 191->65 -> stays FULL, valve0=0. level0=64 -> FILL, valve0=1.
- Arbitration, MAX_ON=2, all levels=10 -> valve=0011, active_cnt=2. ch0 level=200 -> next edge valve=0110. ch2 timer resumes from its frozen value, not 0.
- Timeout, FILL_TIMEOUT=1000, level0 held 10 -> valve0 high exactly 1000 cycles, then state0=4, err0=1, timeout_flag0=1, valve0=0. fault_ack0 pulse -> IDLE, then FILL.
- Fault priority: ch1 FILL, fault1=1 with level1=200 same cycle -> FAULT (state=3), valve1=0. Ack while fault1=1 -> stays FAULT. Ack after fault1=0 -> IDLE.
- Async reset while valve=1111 (MAX_ON=4): reset low mid-cycle -> valve=0000 before next edge. With TANK_FAULT_DEBOUNCE_EN, a 3-cycle fault pulse is ignored and a 4-cycle pulse gives FAULT.
